// File: rtl/ir_strobe_pkg.sv
// Shared types and default parameters for the IR LED strobe controller.
// The optional watchdog is enabled by defining IR_STROBE_LIMIT_EN.
package ir_strobe_pkg;

  localparam int DUTY_W_DEF     = 8;
  localparam int PRE_W_DEF      = 16;
  localparam int LEN_W_DEF      = 24;
  localparam int WARMUP_CYC_DEF = 64;
  localparam int MAX_ON_CYC_DEF = 2 ** 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    ON   = 2'd2
  } state_e;

endpackage

// File: rtl/ir_pwm_gen.sv
// PWM generator for IRPWM: prescaler, free-running duty counter and registered compare.
// Output is registered so it lines up with the registered IRLEDEN from the top level.
module ir_pwm_gen #(
  parameter int DUTY_W = 8,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              run,
  input  logic [DUTY_W-1:0] duty,
  input  logic [PRE_W-1:0]  prescale,
  output logic              pwm
);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              pwm_q, pwm_d;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (run) begin
      if (pre_q == prescale) begin
        pre_d = '0;
        cnt_d = cnt_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    // Compare against the count of the cycle being presented, so ON entry shows count 0.
    pwm_d = run && (cnt_d < duty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/ir_strobe_ctrl.sv
// IR LED strobe sequencer: CURREN warm-up, then a timed IRLEDEN window with PWM on IRPWM.
// Define IR_STROBE_LIMIT_EN to add the continuous-on watchdog and sticky fault.
module ir_strobe_ctrl
  import ir_strobe_pkg::*;
#(
  parameter int WARMUP_CYC = WARMUP_CYC_DEF,
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int PRE_W      = PRE_W_DEF,
  parameter int LEN_W      = LEN_W_DEF
`ifdef IR_STROBE_LIMIT_EN
  ,
  parameter int MAX_ON_CYC = MAX_ON_CYC_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [DUTY_W-1:0] cfg_duty,
  input  logic [PRE_W-1:0]  cfg_prescale,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              trig,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              curren,
  output logic              irleden,
  output logic              irpwm
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              curren_q, curren_d;
  logic              irleden_q, irleden_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pwm_clr;
  logic              wd_trip;
  logic              fault_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    pre_d   = pre_q;
    len_d   = len_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig && cfg_en && !fault_q) begin
          state_d = WARM;
          cnt_d   = '0;
          duty_d  = cfg_duty;
          pre_d   = cfg_prescale;
          len_d   = cfg_len;
        end
      end
      WARM: begin
        if (cnt_q == LEN_W'(WARMUP_CYC - 1)) begin
          cnt_d = '0;
          if (len_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ON;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ON: begin
        if (cnt_q == len_q - 1'b1) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable and watchdog trips end the sequence silently, overriding normal completion.
    if (!cfg_en || wd_trip) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
    pwm_clr   = (state_q != ON) && (state_d == ON);
    curren_d  = (state_d != IDLE);
    irleden_d = (state_d == ON);
    busy_d    = curren_d;
  end

`ifdef IR_STROBE_LIMIT_EN
  localparam int WD_W = $clog2(MAX_ON_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d, wd_inc;
  logic            fault_d;

  always_comb begin
    wd_inc  = wd_q + 1'b1;
    wd_trip = irleden_q && (wd_inc == WD_W'(MAX_ON_CYC));
    wd_d    = (irleden_q && !wd_trip) ? wd_inc : '0;
    fault_d = cfg_en && (fault_q || wd_trip);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign fault_q = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      duty_q    <= '0;
      pre_q     <= '0;
      len_q     <= '0;
      curren_q  <= 1'b0;
      irleden_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      pre_q     <= pre_d;
      len_q     <= len_d;
      curren_q  <= curren_d;
      irleden_q <= irleden_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  ir_pwm_gen #(
    .DUTY_W (DUTY_W),
    .PRE_W  (PRE_W)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .clr      (pwm_clr),
    .run      (irleden_d),
    .duty     (duty_q),
    .prescale (pre_q),
    .pwm      (irpwm)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign fault   = fault_q;
  assign curren  = curren_q;
  assign irleden = irleden_q;

endmodule
